controller_debounce: RTL and testbench
======================================

# controller_debounce

Front-end for the 5-button controller. It synchronizes the raw asynchronous button pins and debounces each button independently. It drives the CPU's `controller_in` port with clean levels and also produces per-button press events: one-cycle pulses plus sticky latches that software-visible logic acknowledges. It sits directly upstream of `CPU.controller_in`, between the board pins and the processor.

## Interface
- `N_BUTTONS`, 5, number of buttons (bit i = button i throughout).
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- `ACTIVE_LOW`, 1, 1 = raw pin low means pressed; 0 = raw pin high means pressed.
- `REPEAT_DELAY`, 25000000, hold cycles before the first auto-repeat pulse (used only with `CTRL_AUTOREPEAT_EN`).
- `REPEAT_PERIOD`, 5000000, cycles between subsequent auto-repeat pulses (used only with `CTRL_AUTOREPEAT_EN`).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `buttons_raw`  in  N_BUTTONS  asynchronous raw pins, polarity per `ACTIVE_LOW`.
- `ack`  in  N_BUTTONS  per-bit clear of `press_latched`.
- `controller_in`  out  N_BUTTONS  debounced level, 1 = pressed; feeds `CPU.controller_in`.
- `press_pulse`  out  N_BUTTONS  one-cycle pulse per accepted press (and per auto-repeat).
- `press_latched`  out  N_BUTTONS  sticky press flag, held until acked.

## Operation
- **Polarity normalization:** raw pins are inverted when `ACTIVE_LOW`=1. All internal state is "1 = pressed".
- **Synchronizer:** two flops per bit (`sync1`, `sync2`). Reset loads the "not pressed" level (0 after normalization).
- **Debounce, per bit,** with counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`:
  - `sync2 == stable`: `cnt <= 0`.
  - `sync2 != stable` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` consecutive mismatching cycles is discarded; the counter restarts on each return to the stable level.
- **Output:** `controller_in = stable`, driven straight from the register.
- **press_pulse[i]:** registered. Set on the same edge that `stable[i]` goes 0→1, cleared the next edge. A release (1→0) produces no pulse.
- **press_latched[i]:** set on any cycle that `press_pulse[i]` is set; cleared on an edge where `ack[i]`=1. If set and ack occur on the same edge, set wins, so no event is lost.
- **Independence:** buttons never interact. Any combination may change in the same cycle.

## Timing
- **Reset values:** all outputs 0, all `cnt` 0, sync flops and `stable` 0.
- **Reset mid-debounce:** the pending change is abandoned. After reset deasserts, a held button is re-qualified from scratch and produces a fresh press pulse.
- **Press latency:** if `buttons_raw` changes and is first captured in `sync1` at edge k, `sync2` updates at k+1. `stable`, `press_pulse` and `press_latched` update at edge k+1+`DEBOUNCE_CYCLES`, giving a latency of `DEBOUNCE_CYCLES`+2 edges including k.
- **Release latency:** identical to press latency.
- **Ack latency:** `press_latched` clears one edge after `ack` is sampled high.
- **Pulse width:** `press_pulse` is exactly one cycle wide. Pulses for successive presses are separated by at least 2·`DEBOUNCE_CYCLES` cycles.

## Configuration
- **Macro:** `CTRL_AUTOREPEAT_EN`.
- **Defined:** each bit has a hold counter of width `$clog2(REPEAT_DELAY)`.
  - The counter is cleared when `stable[i]`=0 and counts while `stable[i]`=1.
  - First repeat: `REPEAT_DELAY` cycles after the accepted press edge, it raises `press_pulse[i]` (and sets `press_latched[i]`).
  - Subsequent repeats: every `REPEAT_PERIOD` cycles thereafter while the button is held.
  - Release stops repeats immediately.
- **Undefined:** no hold counters are built. The `REPEAT_*` parameters are ignored, and one pulse is produced per press.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `ACTIVE_LOW`=1, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=4.
1. **Reset:** hold `reset`=1 with `buttons_raw`=5'b00000 (all pressed) → all outputs 0 during reset. After release, `controller_in`=5'b11111 and `press_pulse`=5'b11111 for one cycle, at the 6th edge after reset deasserts.
2. **Clean press:** drive bit 2 low and hold → `controller_in[2]` rises exactly 6 edges after first capture. `press_pulse[2]` is high for 1 cycle. `press_latched`=5'b00100 until `ack`=5'b00100, then clears the next edge.
3. **Glitch rejection:** low pulses of 1, 2 and 3 cycles on bit 0, each separated by 1 high cycle → `controller_in[0]` stays 0 with no pulse. A 5-cycle low pulse is accepted.
4. **Simultaneous set and ack:** hold `ack[3]`=1 continuously while pressing bit 3 → `press_latched[3]` is 1 after the press edge. Next edge with `ack` still high, it clears.
5. **Multi-button and release:** press bits 0 and 4 in the same cycle → both pulse on the same edge. Release bit 4 → `controller_in`=5'b00001 after 6 edges, with no pulse.
6. **`CTRL_AUTOREPEAT_EN` (defined):** hold bit 1 for 30 cycles after acceptance → pulses at +0, +8, +12, +16, +20, +24, +28. Release → no further pulses. With the macro undefined, the same stimulus gives the +0 pulse only.

Source files
------------

// File: rtl/controller_debounce.sv
// Button front-end: 2-flop synchronizer, per-bit debounce, press pulses and sticky press latches.
// Define CTRL_AUTOREPEAT_EN to add per-button hold counters that re-fire press_pulse while held.
module controller_debounce #(
  parameter int N_BUTTONS       = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  input  logic [N_BUTTONS-1:0] ack,
  output logic [N_BUTTONS-1:0] controller_in,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] press_latched
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0] norm;
  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;
  logic [N_BUTTONS-1:0] stable;
  logic [N_BUTTONS-1:0] stable_nxt;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] repeat_hit;
  logic [N_BUTTONS-1:0] pulse_nxt;
  logic [CW-1:0]        cnt     [N_BUTTONS];
  logic [CW-1:0]        cnt_nxt [N_BUTTONS];

  assign norm = ACTIVE_LOW ? ~buttons_raw : buttons_raw;

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) begin
          stable_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise      = stable_nxt & ~stable;
  assign pulse_nxt = rise | repeat_hit;

`ifdef CTRL_AUTOREPEAT_EN
  localparam int            HW          = $clog2(REPEAT_DELAY);
  localparam logic [HW-1:0] HOLD_MAX    = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [HW-1:0] hold     [N_BUTTONS];
  logic [HW-1:0] hold_nxt [N_BUTTONS];

  // Reloading to DELAY-PERIOD makes later repeats arrive every REPEAT_PERIOD cycles;
  // gating with stable_nxt suppresses a repeat on the very edge the release lands.
  always_comb begin
    repeat_hit = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      hold_nxt[i] = '0;
      if (stable[i]) begin
        if (hold[i] == HOLD_MAX) begin
          hold_nxt[i]   = HOLD_RELOAD;
          repeat_hit[i] = stable_nxt[i];
        end else begin
          hold_nxt[i] = hold[i] + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_BUTTONS; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) hold[i] <= hold_nxt[i];
    end
  end
`else
  assign repeat_hit = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      stable        <= '0;
      press_pulse   <= '0;
      press_latched <= '0;
      for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      sync1         <= norm;
      sync2         <= sync1;
      stable        <= stable_nxt;
      press_pulse   <= pulse_nxt;
      press_latched <= pulse_nxt | (press_latched & ~ack);
      for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign controller_in = stable;

endmodule

// File: tb/tb_controller_debounce.sv
// Self-checking bench for controller_debounce: table of per-step vectors plus a held-button
// repeat sequence; expectations are queued when stimulus is driven and compared after the edge.
module tb_controller_debounce;

  localparam int N = 5;

`ifdef CTRL_AUTOREPEAT_EN
  localparam logic AR = 1'b1;
`else
  localparam logic AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] buttons_raw;
  logic [N-1:0] ack;
  logic [N-1:0] controller_in;
  logic [N-1:0] press_pulse;
  logic [N-1:0] press_latched;

  always #5 clk = ~clk;

  controller_debounce #(
    .N_BUTTONS(N),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .buttons_raw(buttons_raw),
    .ack(ack),
    .controller_in(controller_in),
    .press_pulse(press_pulse),
    .press_latched(press_latched)
  );

  typedef struct {
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] ack;
    int           cycles;
    logic [N-1:0] e_ctrl;
    logic [N-1:0] e_pulse;
    logic [N-1:0] e_lat;
  } vec_t;

  typedef struct {
    logic [N-1:0] ctrl;
    logic [N-1:0] pulse;
    logic [N-1:0] lat;
    int           tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void add(input logic rst, input logic [N-1:0] raw, input logic [N-1:0] ak,
                              input int cycles, input logic [N-1:0] c, input logic [N-1:0] p,
                              input logic [N-1:0] l);
    vec_t v;
    v.rst = rst; v.raw = raw; v.ack = ak; v.cycles = cycles;
    v.e_ctrl = c; v.e_pulse = p; v.e_lat = l;
    vecs.push_back(v);
  endfunction

  task automatic compare(input string name, input int tag, input logic [N-1:0] got,
                         input logic [N-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s step %0d: got %b, expected %b", name, tag, got, want);
  endtask

  // Drives one vector at the falling edge, queues its expectation, then lets it run.
  task automatic applyStimulus(input logic rst, input logic [N-1:0] raw, input logic [N-1:0] ak,
                               input int cycles, input exp_t e);
    @(negedge clk);
    reset       = rst;
    buttons_raw = raw;
    ack         = ak;
    sb.push_back(e);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      compare("controller_in", e.tag, controller_in, e.ctrl);
      compare("press_pulse", e.tag, press_pulse, e.pulse);
      compare("press_latched", e.tag, press_latched, e.lat);
    end
  endtask

  initial begin
    exp_t e;
    reset       = 1'b1;
    buttons_raw = 5'b11111;
    ack         = 5'b00000;

    // reset with everything pressed, then qualification 6 edges after deassert
    add(1, 5'b00000, 5'b00000, 3, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00000, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b11111, 5'b11111);
    add(0, 5'b00000, 5'b00000, 1, 5'b11111, 5'b00000, 5'b11111);
    add(0, 5'b11111, 5'b11111, 1, 5'b11111, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 4, 5'b11111, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    // clean press of bit 2, ack clears latch
    add(0, 5'b11011, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11011, 5'b00000, 1, 5'b00100, 5'b00100, 5'b00100);
    add(0, 5'b11011, 5'b00000, 1, 5'b00100, 5'b00000, 5'b00100);
    add(0, 5'b11111, 5'b00100, 1, 5'b00100, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 4, 5'b00100, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    // glitches of 1, 2, 3 cycles on bit 0 are rejected
    add(0, 5'b11110, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11110, 5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11110, 5'b00000, 3, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 6, 5'b00000, 5'b00000, 5'b00000);
    // a 5-cycle low pulse is accepted, then released
    add(0, 5'b11110, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00001, 5'b00001, 5'b00001);
    add(0, 5'b11111, 5'b00000, 4, 5'b00001, 5'b00000, 5'b00001);
    add(0, 5'b11111, 5'b00001, 1, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 2, 5'b00000, 5'b00000, 5'b00000);
    // ack held on bit 3 while it is pressed: set wins, then clears
    add(0, 5'b10111, 5'b01000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b10111, 5'b01000, 1, 5'b01000, 5'b01000, 5'b01000);
    add(0, 5'b10111, 5'b01000, 1, 5'b01000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 5, 5'b01000, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    // bits 0 and 4 together, release 4 (no pulse), then release 0 while a repeat is pending
    add(0, 5'b01110, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b01110, 5'b00000, 1, 5'b10001, 5'b10001, 5'b10001);
    add(0, 5'b11110, 5'b10001, 1, 5'b10001, 5'b00000, 5'b00000);
    add(0, 5'b11110, 5'b00000, 4, 5'b10001, 5'b00000, 5'b00000);
    add(0, 5'b11110, 5'b00000, 1, 5'b00001, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00001, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00001, {4'b0000, AR}, {4'b0000, AR});
    add(0, 5'b11111, 5'b11111, 3, 5'b00001, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    // reset in the middle of a debounce: held button re-qualifies from scratch
    add(0, 5'b11011, 5'b00000, 3, 5'b00000, 5'b00000, 5'b00000);
    add(1, 5'b11011, 5'b00000, 1, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11011, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11011, 5'b00000, 1, 5'b00100, 5'b00100, 5'b00100);
    add(0, 5'b11111, 5'b00100, 1, 5'b00100, 5'b00000, 5'b00000);
    add(0, 5'b11111, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000);
    // press bit 1 for the hold sequence below
    add(0, 5'b11101, 5'b00000, 5, 5'b00000, 5'b00000, 5'b00000);
    add(0, 5'b11101, 5'b00000, 1, 5'b00010, 5'b00010, 5'b00010);

    foreach (vecs[i]) begin
      e.ctrl = vecs[i].e_ctrl; e.pulse = vecs[i].e_pulse; e.lat = vecs[i].e_lat; e.tag = i;
      applyStimulus(vecs[i].rst, vecs[i].raw, vecs[i].ack, vecs[i].cycles, e);
      checkOutput();
    end

    // Bit 1 held; acceptance was offset 0. Release is captured at +25 and lands at +30.
    // With ack held, the latch follows the pulse exactly.
    for (int off = 1; off <= 40; off++) begin
      logic rep;
      rep     = AR && (off >= 8) && (off <= 28) && (off % 4 == 0);
      e.ctrl  = (off < 30) ? 5'b00010 : 5'b00000;
      e.pulse = {3'b000, rep, 1'b0};
      e.lat   = {3'b000, rep, 1'b0};
      e.tag   = 1000 + off;
      applyStimulus(1'b0, (off >= 25) ? 5'b11111 : 5'b11101, 5'b00010, 1, e);
      checkOutput();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
